// File: rtl/dram_axi_pkg.sv
// Shared constants and FSM state types for the DRAM reader/writer AXI3 masters.
// Both blocks move data in fixed 16-beat, 8-byte-per-beat INCR bursts.
package dram_axi_pkg;

  localparam int unsigned BURST_BEATS    = 16;
  localparam int unsigned BURST_BYTES    = 128;
  localparam logic [3:0]  AXI_LEN_16     = 4'b1111;
  localparam logic [1:0]  AXI_SIZE_8B    = 2'b11;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  typedef enum logic {
    A_IDLE,
    A_ISSUE
  } a_state_e;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } r_state_e;

endpackage

// File: rtl/dram_reader.sv
// AXI3 read master: fetches a contiguous DRAM region in 128-byte bursts and
// streams the 64-bit beats out on a valid/ready interface with no buffering.
module dram_reader
  import dram_axi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [3:0]  M_AXI_ARLEN,
  output logic [1:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic        CONFIG_VALID,
  output logic        CONFIG_READY,
  input  logic [31:0] CONFIG_START_ADDR,
  input  logic [31:0] CONFIG_NBYTES,
  output logic [63:0] DATA,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic        ERROR
);

  a_state_e    a_state_q, a_state_d;
  r_state_e    r_state_q, r_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [24:0] a_count_q, a_count_d;
  logic [28:0] beats_left_q, beats_left_d;
  logic [3:0]  beat_idx_q, beat_idx_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        error_q, error_d;

  logic cfg_accept;
  logic streaming;
  logic ar_hs;
  logic beat;
  logic burst_done;
  logic unused_cfg_bits;

  // Sub-burst address/length bits are dropped: jobs are whole aligned bursts.
  assign unused_cfg_bits = ^{CONFIG_START_ADDR[6:0], CONFIG_NBYTES[6:0]};

  assign M_AXI_ARLEN   = AXI_LEN_16;
  assign M_AXI_ARSIZE  = AXI_SIZE_8B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARADDR  = araddr_q;
  assign ERROR         = error_q;

  assign CONFIG_READY  = (a_state_q == A_IDLE) && (r_state_q == R_IDLE);
  assign cfg_accept    = CONFIG_VALID && CONFIG_READY;

  assign M_AXI_ARVALID = (a_state_q == A_ISSUE) &&
                         (32'(outstanding_q) < MAX_OUTSTANDING);
  assign ar_hs         = M_AXI_ARVALID && M_AXI_ARREADY;

  // Read channel is wired straight through to the stream while a job runs.
  assign streaming     = (r_state_q == R_STREAM);
  assign DATA          = M_AXI_RDATA;
  assign DATA_VALID    = streaming && M_AXI_RVALID;
  assign M_AXI_RREADY  = streaming && DATA_READY;
  assign beat          = DATA_VALID && DATA_READY;
  assign burst_done    = beat && (beat_idx_q == 4'hF);

  always_comb begin
    a_state_d     = a_state_q;
    r_state_d     = r_state_q;
    araddr_d      = araddr_q;
    a_count_d     = a_count_q;
    beats_left_d  = beats_left_q;
    beat_idx_d    = beat_idx_q;
    outstanding_d = outstanding_q;
    error_d       = error_q;

    if (cfg_accept) begin
      a_count_d    = CONFIG_NBYTES[31:7];
      beats_left_d = {CONFIG_NBYTES[31:7], 4'b0000};
      araddr_d     = {CONFIG_START_ADDR[31:7], 7'b0};
      beat_idx_d   = '0;
      error_d      = 1'b0;
      if (CONFIG_NBYTES[31:7] != '0) begin
        a_state_d = A_ISSUE;
        r_state_d = R_STREAM;
      end
    end

    if (ar_hs) begin
      araddr_d  = araddr_q + 32'(BURST_BYTES);
      a_count_d = a_count_q - 25'd1;
      if (a_count_q == 25'd1) a_state_d = A_IDLE;
    end

    if (beat) begin
      beats_left_d = beats_left_q - 29'd1;
      beat_idx_d   = beat_idx_q + 4'd1;
      if (beats_left_q == 29'd1) r_state_d = R_IDLE;
      if ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != (beat_idx_q == 4'hF)))
        error_d = 1'b1;
    end

    // An issue and a retire in the same cycle cancel out.
    case ({ar_hs, burst_done})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      a_state_q     <= A_IDLE;
      r_state_q     <= R_IDLE;
      araddr_q      <= '0;
      a_count_q     <= '0;
      beats_left_q  <= '0;
      beat_idx_q    <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      a_state_q     <= a_state_d;
      r_state_q     <= r_state_d;
      araddr_q      <= araddr_d;
      a_count_q     <= a_count_d;
      beats_left_q  <= beats_left_d;
      beat_idx_q    <= beat_idx_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

endmodule
